// File: rtl/job_assignment_machine_pkg.sv
// Shared types and constants for the exhaustive job-assignment search.
package job_assignment_machine_pkg;

    localparam int unsigned N_WORKERS = 8;
    localparam int unsigned N_PERMS   = 40320;
    localparam int unsigned COST_W    = 7;
    localparam int unsigned SUM_W     = 10;
    localparam int unsigned COUNT_MAX = 15;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned COUNT_W   = 4;
    localparam int unsigned MIN_OUT_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EVAL,
        DONE
    } state_t;

    // Entry k is the job assigned to worker k.
    typedef logic [N_WORKERS-1:0][IDX_W-1:0] perm_t;

    function automatic perm_t identity_perm();
        perm_t p;
        for (int i = 0; i < N_WORKERS; i++) begin
            p[i] = IDX_W'(i);
        end
        return p;
    endfunction

endpackage

// File: rtl/job_assignment_machine_next_perm.sv
// Combinational successor of a permutation in lexicographic order.
module next_perm
    import job_assignment_machine_pkg::*;
(
    input  perm_t perm,
    output perm_t next,
    output logic  is_last
);

    logic [IDX_W-1:0] piv;
    logic [IDX_W-1:0] succ;
    logic [IDX_W-1:0] src;
    logic             found;
    perm_t            swapped;

    always_comb begin
        piv     = '0;
        succ    = '0;
        src     = '0;
        found   = 1'b0;
        swapped = perm;
        next    = perm;

        // Rightmost ascent; later iterations override earlier ones.
        for (int i = 0; i < N_WORKERS - 1; i++) begin
            if (perm[i] < perm[i+1]) begin
                piv   = IDX_W'(i);
                found = 1'b1;
            end
        end

        for (int j = 0; j < N_WORKERS; j++) begin
            if ((IDX_W'(j) > piv) && (perm[j] > perm[piv])) begin
                succ = IDX_W'(j);
            end
        end

        swapped[piv]  = perm[succ];
        swapped[succ] = perm[piv];

        // Reverse the tail: position k takes piv+8-k, which is piv-k modulo 8.
        for (int k = 0; k < N_WORKERS; k++) begin
            if (IDX_W'(k) > piv) begin
                src     = piv - IDX_W'(k);
                next[k] = swapped[src];
            end else begin
                next[k] = swapped[k];
            end
        end

        if (!found) begin
            next = perm;
        end
        is_last = !found;
    end

endmodule

// File: rtl/job_assignment_machine.sv
// Walks all 8! assignments, summing table costs, and reports the minimum and how many hit it.
module job_assignment_machine
    import job_assignment_machine_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    output logic [IDX_W-1:0]     W,
    output logic [IDX_W-1:0]     J,
    input  logic [COST_W-1:0]    Cost,
    output logic [COUNT_W-1:0]   MatchCount,
    output logic [MIN_OUT_W-1:0] MinCost,
    output logic                 Valid
);

    state_t             state;
    perm_t              perm;
    perm_t              perm_nxt;
    logic               perm_last;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   min_sum;
    logic [COUNT_W-1:0] count;

    next_perm u_next_perm (
        .perm    (perm),
        .next    (perm_nxt),
        .is_last (perm_last)
    );

    // W doubles as the READ-phase index; J is preloaded so Cost is valid in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            perm    <= identity_perm();
            acc     <= '0;
            min_sum <= '1;
            count   <= '0;
            Valid   <= 1'b0;
            W       <= '0;
            J       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= READ;
                    acc   <= '0;
                    W     <= '0;
                    J     <= perm[0];
                end
                READ: begin
                    acc <= acc + SUM_W'(Cost);
                    if (W == IDX_W'(N_WORKERS - 1)) begin
                        state <= EVAL;
                        W     <= '0;
                        J     <= '0;
                    end else begin
                        W <= W + IDX_W'(1);
                        J <= perm[W + IDX_W'(1)];
                    end
                end
                EVAL: begin
                    if (acc < min_sum) begin
                        min_sum <= acc;
                        count   <= COUNT_W'(1);
                    end else if ((acc == min_sum) && (count != COUNT_W'(COUNT_MAX))) begin
                        count <= count + COUNT_W'(1);
                    end
                    perm <= perm_nxt;
                    if (perm_last) begin
                        state <= DONE;
                        Valid <= 1'b1;
                        W     <= '0;
                        J     <= '0;
                    end else begin
                        state <= READ;
                        acc   <= '0;
                        W     <= '0;
                        J     <= perm_nxt[0];
                    end
                end
                DONE: begin
                    Valid <= 1'b1;
                    W     <= '0;
                    J     <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign MinCost    = min_sum[MIN_OUT_W-1:0];
    assign MatchCount = count;

endmodule

// File: tb/tb_job_assignment_machine.sv
// Directed bench: full searches over four cost tables plus an interrupted run.
module tb_job_assignment_machine;

    logic       CLK;
    logic       RST;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic [3:0] MatchCount;
    logic [8:0] MinCost;
    logic       Valid;

    logic [6:0] tbl [0:63];

    int tests;
    int fails;
    int rises;
    int wj_bad;
    logic valid_q;

    localparam int LAT_NOM = 362881;
    localparam int BUDGET  = 362900;

    job_assignment_machine dut (
        .CLK        (CLK),
        .RST        (RST),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .MatchCount (MatchCount),
        .MinCost    (MinCost),
        .Valid      (Valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb Cost = tbl[{W, J}];

    // Whole-run watchers: Valid edges, and W/J idle-at-zero while results are held.
    always @(negedge CLK) begin
        if (RST) begin
            valid_q = 1'b0;
        end else begin
            if ((^{W, J}) === 1'bx) wj_bad++;
            if (Valid === 1'b1 && (W !== 3'd0 || J !== 3'd0)) wj_bad++;
            if (Valid === 1'b1 && valid_q !== 1'b1) rises++;
            valid_q = Valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 0 diagonal, 1 all-zero, 2 i+j, 3 two optima.
    task automatic set_table(input int mode);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                case (mode)
                    0: tbl[i*8+j] = (i == j) ? 7'd1 : 7'd100;
                    1: tbl[i*8+j] = 7'd0;
                    2: tbl[i*8+j] = 7'(i + j);
                    default: tbl[i*8+j] = ((i == j) || (i == 0 && j == 1) || (i == 1 && j == 0)) ? 7'd1 : 7'd50;
                endcase
            end
        end
    endtask

    task automatic run_to_done(input string tag, input int exp_min, input int exp_cnt, input bit seq);
        int lat;
        int exp_j2 [8];
        exp_j2 = '{0, 1, 2, 3, 4, 5, 7, 6};
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check({tag, "_rst_valid_now"}, 32'(Valid), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check({tag, "_rst_valid"}, 32'(Valid), 32'd0);
        check({tag, "_rst_min"}, 32'(MinCost), 32'd511);
        check({tag, "_rst_cnt"}, 32'(MatchCount), 32'd0);
        check({tag, "_rst_wj"}, 32'({W, J}), 32'd0);
        rises  = 0;
        wj_bad = 0;
        @(negedge CLK);
        RST = 1'b0;
        lat = 0;
        while (lat < BUDGET) begin
            @(posedge CLK);
            lat++;
            #1;
            if (seq && lat >= 1 && lat <= 8) begin
                check($sformatf("%s_p0_w%0d", tag, lat - 1), 32'(W), 32'(lat - 1));
                check($sformatf("%s_p0_j%0d", tag, lat - 1), 32'(J), 32'(lat - 1));
            end
            if (seq && lat >= 10 && lat <= 17) begin
                check($sformatf("%s_p1_w%0d", tag, lat - 10), 32'(W), 32'(lat - 10));
                check($sformatf("%s_p1_j%0d", tag, lat - 10), 32'(J), 32'(exp_j2[lat - 10]));
            end
            if (Valid === 1'b1) break;
        end
        check({tag, "_valid_seen"}, 32'(Valid), 32'd1);
        check({tag, "_latency_in_window"},
              32'((lat >= LAT_NOM - 2) && (lat <= LAT_NOM + 2)), 32'd1);
        check({tag, "_mincost"}, 32'(MinCost), 32'(exp_min));
        check({tag, "_matchcount"}, 32'(MatchCount), 32'(exp_cnt));
        repeat (20) @(posedge CLK);
        #1;
        check({tag, "_hold_valid"}, 32'(Valid), 32'd1);
        check({tag, "_hold_min"}, 32'(MinCost), 32'(exp_min));
        check({tag, "_hold_cnt"}, 32'(MatchCount), 32'(exp_cnt));
        check({tag, "_hold_wj"}, 32'({W, J}), 32'd0);
        check({tag, "_valid_rises"}, 32'(rises), 32'd1);
        check({tag, "_wj_watch"}, 32'(wj_bad), 32'd0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rises   = 0;
        wj_bad  = 0;
        valid_q = 1'b0;
        RST     = 1'b1;
        set_table(0);

        run_to_done("diag", 8, 1, 1'b1);

        set_table(1);
        run_to_done("zero", 0, 15, 1'b0);

        set_table(2);
        run_to_done("ipj", 56, 15, 1'b0);

        set_table(3);
        run_to_done("two_opt", 8, 2, 1'b0);

        // Interrupted search: start, abandon after 1000 cycles, then rerun from reset.
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (1000) @(posedge CLK);
        #1;
        check("midrun_valid_low", 32'(Valid), 32'd0);
        run_to_done("restart", 8, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
